// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// mc_ctrl_if : control-unit <-> datapath bundle (IR fields, flags, controls)
// Revision   : 1.0
// ============================================================================
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             pc_wr;
   logic             pc_wr_cond;
   logic             pc_en;
   logic             iord;
   logic             mem_rd;
   logic             mem_wr;
   logic             ir_wr;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             reg_wr;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic             ext_zero;
   logic [2:0]       alu_ctl;
   logic [1:0]       pc_src;
   logic [3:0]       state;
   logic             err;
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] inst_cnt;

   modport master (
      input  opcode, funct, zero,
      output pc_wr, pc_wr_cond, pc_en, iord, mem_rd, mem_wr, ir_wr, reg_dst,
             mem_to_reg, reg_wr, alu_src_a, alu_src_b, ext_zero, alu_ctl,
             pc_src, state, err, cyc_cnt, inst_cnt
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_wr, pc_wr_cond, pc_en, iord, mem_rd, mem_wr, ir_wr, reg_dst,
             mem_to_reg, reg_wr, alu_src_a, alu_src_b, ext_zero, alu_ctl,
             pc_src, state, err, cyc_cnt, inst_cnt
   );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// mc_ctrl  : multi-cycle MIPS control FSM with cycle / retired-instr counters
// Revision : 1.0
// ============================================================================
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  wire logic  clk,
   input  wire logic  rst,
   mc_ctrl_if.master  bus
);
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEM_ADR = 4'd2, S_MEM_RD = 4'd3,
      S_MEM_WB  = 4'd4,  S_MEM_WR = 4'd5,  S_R_EX    = 4'd6, S_R_WB   = 4'd7,
      S_BR      = 4'd8,  S_JMP    = 4'd9,  S_I_EX    = 4'd10, S_I_WB  = 4'd11,
      S_ERR     = 4'd15
   } state_t;

   typedef struct packed {
      logic       pc_wr;
      logic       pc_wr_cond;
      logic       iord;
      logic       mem_rd;
      logic       mem_wr;
      logic       ir_wr;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_wr;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_zero;
      logic [2:0] alu_ctl;
      logic [1:0] pc_src;
      logic       err;
   } ctl_t;

   localparam logic [5:0] c_OP_R    = 6'b000000;
   localparam logic [5:0] c_OP_LW   = 6'b100011;
   localparam logic [5:0] c_OP_SW   = 6'b101011;
   localparam logic [5:0] c_OP_BEQ  = 6'b000100;
   localparam logic [5:0] c_OP_ADDI = 6'b001000;
   localparam logic [5:0] c_OP_ORI  = 6'b001101;
   localparam logic [5:0] c_OP_J    = 6'b000010;
   localparam logic [5:0] c_FN_ADD  = 6'b100000;
   localparam logic [5:0] c_FN_SUB  = 6'b100010;
   localparam logic [5:0] c_FN_AND  = 6'b100100;
   localparam logic [5:0] c_FN_OR   = 6'b100101;
   localparam logic [5:0] c_FN_SLT  = 6'b101010;
   localparam logic [2:0] c_ALU_ADD = 3'b010;
   localparam logic [2:0] c_ALU_SUB = 3'b110;
   localparam logic [2:0] c_ALU_AND = 3'b000;
   localparam logic [2:0] c_ALU_OR  = 3'b001;
   localparam logic [2:0] c_ALU_SLT = 3'b111;

   function automatic logic legal_funct(input logic [5:0] fn);
      return (fn == c_FN_ADD) || (fn == c_FN_SUB) || (fn == c_FN_AND) ||
             (fn == c_FN_OR)  || (fn == c_FN_SLT);
   endfunction

   function automatic logic is_final(input state_t s);
      return (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_R_WB) ||
             (s == S_I_WB)   || (s == S_BR)     || (s == S_JMP);
   endfunction

   function automatic state_t next_of(input state_t s, input logic [5:0] op,
                                      input logic [5:0] fn);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH:   n = S_DECODE;
         S_DECODE: begin
            case (op)
               c_OP_LW, c_OP_SW:    n = S_MEM_ADR;
               c_OP_R:              n = legal_funct(fn) ? S_R_EX : S_ERR;
               c_OP_BEQ:            n = S_BR;
               c_OP_J:              n = S_JMP;
               c_OP_ADDI, c_OP_ORI: n = S_I_EX;
               default:             n = S_ERR;
            endcase
         end
         S_MEM_ADR: n = (op == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:  n = S_MEM_WB;
         S_R_EX:    n = S_R_WB;
         S_I_EX:    n = S_I_WB;
         S_ERR:     n = S_ERR;
         default:   n = S_FETCH;
      endcase
      return n;
   endfunction

   function automatic ctl_t ctl_of(input state_t s, input logic [5:0] op,
                                    input logic [5:0] fn);
      ctl_t c;
      c         = '0;
      c.alu_ctl = c_ALU_ADD;
      case (s)
         S_FETCH: begin
            c.mem_rd = 1'b1; c.ir_wr = 1'b1; c.alu_src_b = 2'b01; c.pc_wr = 1'b1;
         end
         S_DECODE:  c.alu_src_b = 2'b11;
         S_MEM_ADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_MEM_RD:  begin c.mem_rd = 1'b1; c.iord = 1'b1; end
         S_MEM_WB:  begin c.reg_wr = 1'b1; c.mem_to_reg = 1'b1; end
         S_MEM_WR:  begin c.mem_wr = 1'b1; c.iord = 1'b1; end
         S_R_EX: begin
            c.alu_src_a = 1'b1;
            case (fn)
               c_FN_SUB: c.alu_ctl = c_ALU_SUB;
               c_FN_AND: c.alu_ctl = c_ALU_AND;
               c_FN_OR:  c.alu_ctl = c_ALU_OR;
               c_FN_SLT: c.alu_ctl = c_ALU_SLT;
               default:  c.alu_ctl = c_ALU_ADD;
            endcase
         end
         S_R_WB: begin c.reg_wr = 1'b1; c.reg_dst = 1'b1; end
         S_BR: begin
            c.alu_src_a = 1'b1; c.alu_ctl = c_ALU_SUB;
            c.pc_wr_cond = 1'b1; c.pc_src = 2'b01;
         end
         S_JMP: begin c.pc_wr = 1'b1; c.pc_src = 2'b10; end
         S_I_EX: begin
            c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            if (op == c_OP_ORI) begin
               c.alu_ctl  = c_ALU_OR;
               c.ext_zero = 1'b1;
            end
         end
         S_I_WB: begin c.reg_wr = 1'b1; c.ext_zero = (op == c_OP_ORI); end
         S_ERR:  c.err = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   state_t           r_state;
   ctl_t             r_ctl;
   logic [5:0]       r_op;
   logic [5:0]       r_fn;
   logic [CNT_W-1:0] r_cyc_cnt;
   logic [CNT_W-1:0] r_inst_cnt;

   // In DECODE the live IR fields are used; afterwards only the latched copy.
   logic [5:0] w_op;
   logic [5:0] w_fn;
   state_t     w_next;
   assign w_op   = (r_state == S_DECODE) ? bus.opcode : r_op;
   assign w_fn   = (r_state == S_DECODE) ? bus.funct  : r_fn;
   assign w_next = next_of(r_state, w_op, w_fn);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_FETCH;
         r_ctl      <= ctl_of(S_FETCH, 6'd0, 6'd0);
         r_op       <= 6'd0;
         r_fn       <= 6'd0;
         r_cyc_cnt  <= '0;
         r_inst_cnt <= '0;
      end else begin
         r_state   <= w_next;
         r_ctl     <= ctl_of(w_next, w_op, w_fn);
         r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
         if (r_state == S_DECODE) begin
            r_op <= bus.opcode;
            r_fn <= bus.funct;
         end
         if (is_final(r_state) && (w_next == S_FETCH))
            r_inst_cnt <= r_inst_cnt + CNT_W'(1);
      end
   end

   assign bus.pc_wr      = rst & r_ctl.pc_wr;
   assign bus.pc_wr_cond = rst & r_ctl.pc_wr_cond;
   assign bus.pc_en      = rst & (r_ctl.pc_wr | (r_ctl.pc_wr_cond & bus.zero));
   assign bus.mem_rd     = rst & r_ctl.mem_rd;
   assign bus.mem_wr     = rst & r_ctl.mem_wr;
   assign bus.ir_wr      = rst & r_ctl.ir_wr;
   assign bus.reg_wr     = rst & r_ctl.reg_wr;
   assign bus.iord       = r_ctl.iord;
   assign bus.reg_dst    = r_ctl.reg_dst;
   assign bus.mem_to_reg = r_ctl.mem_to_reg;
   assign bus.alu_src_a  = r_ctl.alu_src_a;
   assign bus.alu_src_b  = r_ctl.alu_src_b;
   assign bus.ext_zero   = r_ctl.ext_zero;
   assign bus.alu_ctl    = r_ctl.alu_ctl;
   assign bus.pc_src     = r_ctl.pc_src;
   assign bus.err        = r_ctl.err;
   assign bus.state      = r_state;
   assign bus.cyc_cnt    = r_cyc_cnt;
   assign bus.inst_cnt   = r_inst_cnt;
endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mc_ctrl : random instruction stream vs. per-instruction state/ctl model
// Revision   : 1.0
// ============================================================================
module tb_mc_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rst_w = 1'b0;
   always #5 clk = ~clk;

   mc_ctrl_if #(.CNT_W(32)) bus ();
   mc_ctrl_if #(.CNT_W(4))  bw ();
   mc_ctrl #(.CNT_W(32)) dut   (.clk(clk), .rst(rst),   .bus(bus));
   mc_ctrl #(.CNT_W(4))  dut_w (.clk(clk), .rst(rst_w), .bus(bw));

   typedef int iq_t[$];
   typedef struct {
      bit          full;
      logic [3:0]  st;
      logic [19:0] ctl;
      logic [31:0] cyc;
      logic [31:0] inst;
   } exp_t;

   localparam logic [19:0] c_EN_MASK = 20'hEE400;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_cyc   = 0;
   logic [31:0] m_inst  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic bit legal_r(input logic [5:0] fn);
      return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   endfunction

   // State path of one instruction, FETCH through its last state.
   function automatic iq_t seq_of(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b000000: return legal_r(fn) ? '{0, 1, 6, 7} : '{0, 1, 15};
         6'b100011: return '{0, 1, 2, 3, 4};
         6'b101011: return '{0, 1, 2, 5};
         6'b000100: return '{0, 1, 8};
         6'b001000, 6'b001101: return '{0, 1, 10, 11};
         6'b000010: return '{0, 1, 9};
         default:   return '{0, 1, 15};
      endcase
   endfunction

   function automatic logic [19:0] exp_ctl(input int st, input logic [5:0] op,
                                           input logic [5:0] fn, input bit r, input bit z);
      logic pw, pwc, pen, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ez, er;
      logic [1:0] asb, ps;
      logic [2:0] ac;
      {pw, pwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ez, er} = '0;
      asb = 2'b00; ps = 2'b00; ac = 3'b010;
      case (st)
         0:  begin mrd = 1; irw = 1; asb = 2'b01; pw = 1; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; iord = 1; end
         6: begin
            asa = 1;
            case (fn)
               6'b100010: ac = 3'b110;
               6'b100100: ac = 3'b000;
               6'b100101: ac = 3'b001;
               6'b101010: ac = 3'b111;
               default:   ac = 3'b010;
            endcase
         end
         7:  begin rw = 1; rdst = 1; end
         8:  begin asa = 1; ac = 3'b110; pwc = 1; ps = 2'b01; end
         9:  begin pw = 1; ps = 2'b10; end
         10: begin asa = 1; asb = 2'b10; if (op == 6'b001101) begin ac = 3'b001; ez = 1; end end
         11: begin rw = 1; ez = (op == 6'b001101); end
         15: er = 1;
         default: ;
      endcase
      if (!r) {pw, pwc, mrd, mwr, irw, rw} = '0;
      pen = pw | (pwc & z);
      return {pw, pwc, pen, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, ez, ac, ps, er};
   endfunction

   function automatic logic [19:0] act_ctl();
      return {bus.pc_wr, bus.pc_wr_cond, bus.pc_en, bus.iord, bus.mem_rd, bus.mem_wr,
              bus.ir_wr, bus.reg_dst, bus.mem_to_reg, bus.reg_wr, bus.alu_src_a,
              bus.alu_src_b, bus.ext_zero, bus.alu_ctl, bus.pc_src, bus.err};
   endfunction

   // One clock of stimulus: drive inputs, queue the expected view of this cycle.
   task automatic cycle(input bit r, input int st, input bit full, input logic [5:0] dop,
                        input logic [5:0] dfn, input bit z, input logic [5:0] op,
                        input logic [5:0] fn, input bit retire);
      exp_t e;
      @(posedge clk); #1;
      rst = r; bus.opcode = dop; bus.funct = dfn; bus.zero = z;
      e.full = full; e.st = 4'(st); e.ctl = exp_ctl(st, op, fn, r, z);
      e.cyc = m_cyc; e.inst = m_inst;
      q.push_back(e);
      if (!r) begin
         m_cyc = 0; m_inst = 0;
      end else begin
         m_cyc++;
         if (retire) m_inst++;
      end
   endtask

   // zsel: 0/1 fixes the zero flag, 2 randomises it. abort_at: index pulsing rst low.
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input int zsel, input int abort_at);
      iq_t s;
      bit  legal, r, z;
      s = seq_of(op, fn);
      legal = (s[s.size()-1] != 15);
      for (int i = 0; i < s.size(); i++) begin
         r = (i != abort_at);
         z = (zsel == 2) ? 1'($urandom) : 1'(zsel);
         cycle(r, s[i], 1'b1, (i == 1) ? op : 6'($urandom), (i == 1) ? fn : 6'($urandom),
               z, op, fn, legal && r && (i == s.size() - 1));
         if (!r) return;
      end
   endtask

   task automatic err_then_reset(input logic [5:0] op, input logic [5:0] fn, input int hold);
      run(op, fn, 2, -1);
      for (int i = 0; i < hold; i++)
         cycle(1'b1, 15, 1'b1, 6'($urandom), 6'($urandom), 1'($urandom), op, fn, 1'b0);
      cycle(1'b0, 15, 1'b1, 6'($urandom), 6'($urandom), 1'($urandom), op, fn, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.full) begin
               chk("state", 32'(bus.state), 32'(e.st));
               chk("ctl", 32'(act_ctl()), 32'(e.ctl));
               chk("cyc_cnt", bus.cyc_cnt, e.cyc);
               chk("inst_cnt", bus.inst_cnt, e.inst);
            end else begin
               chk("reset_enables", 32'(act_ctl() & c_EN_MASK), 32'd0);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      logic [5:0] ops[7];
      logic [5:0] fns[5];
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b001101, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
      bw.opcode = '0; bw.funct = 6'b100000; bw.zero = 1'b0;

      cycle(1'b0, 0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0);
      cycle(1'b0, 0, 1'b1, 6'd0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0);

      run(6'b000000, 6'b100000, 2, -1);
      run(6'b100011, 6'($urandom), 2, -1);
      run(6'b101011, 6'($urandom), 2, -1);
      run(6'b000100, 6'($urandom), 1, -1);
      run(6'b000100, 6'($urandom), 0, -1);
      run(6'b001101, 6'($urandom), 2, -1);
      run(6'b000010, 6'($urandom), 2, -1);

      for (int n = 0; n < 60; n++) begin
         logic [5:0] op;
         op = ops[$urandom_range(0, 6)];
         run(op, (op == 6'b000000) ? fns[$urandom_range(0, 4)] : 6'($urandom), 2, -1);
      end

      run(6'b100011, 6'($urandom), 2, 3);
      run(6'b000000, 6'b100101, 2, -1);
      err_then_reset(6'b111111, 6'($urandom), 5);
      err_then_reset(6'b000000, 6'b000000, 3);
      run(6'b000000, 6'b101010, 2, -1);

      @(posedge clk); #1;
      rst_w = 1'b0;
      @(posedge clk); #1;
      rst_w = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("wrap_cyc", 32'(bw.cyc_cnt), 32'(k % 16));
         chk("wrap_inst", 32'(bw.inst_cnt), 32'((k / 4) % 16));
      end

      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the `mach` single-issue MIPS datapath. It decodes the instruction register opcode and funct fields and steps a Moore state machine through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath's mux selects, write enables and ALU control. It also keeps cycle and retired-instruction counters for the bench and for debug readout.

## Interface
- `CNT_W`, default 32: width of the cycle and retired-instruction counters.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, combinational from the datapath.
- `pc_wr` out 1: unconditional PC write.
- `pc_wr_cond` out 1: PC write if `zero`.
- `pc_en` out 1: equals `pc_wr | (pc_wr_cond & zero)`.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_rd` out 1: memory read enable.
- `mem_wr` out 1: memory write enable.
- `ir_wr` out 1: IR load enable.
- `reg_dst` out 1: write register select, 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-data select, 0 = ALUOut, 1 = MDR.
- `reg_wr` out 1: register file write enable.
- `alu_src_a` out 1: ALU A select, 0 = PC, 1 = A register.
- `alu_src_b` out 2: ALU B select, 00 = B, 01 = 4, 10 = extended imm, 11 = sign-extended imm<<2.
- `ext_zero` out 1: immediate extend mode, 1 = zero-extend.
- `alu_ctl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_src` out 2: PC source, 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` out 4: current state, for debug.
- `err` out 1: sticky illegal-instruction flag.
- `cyc_cnt` out CNT_W: cycles since reset.
- `inst_cnt` out CNT_W: retired instructions.

## Operation
- Supported opcodes:
  - R-type 000000, funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - lw 100011, sw 101011, beq 000100, addi 001000, ori 001101, j 000010.
- States, 4-bit encoding:
  - FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
  - R_EX=6, R_WB=7, BR=8, JMP=9, I_EX=10, I_WB=11, ERR=15.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEM_ADR (lw/sw), R_EX (R with legal funct), BR (beq), JMP (j), I_EX (addi/ori), ERR (anything else).
  - MEM_ADR -> MEM_RD (lw) or MEM_WR (sw); MEM_RD -> MEM_WB.
  - R_EX -> R_WB; I_EX -> I_WB.
  - MEM_WB, MEM_WR, R_WB, I_WB, BR, JMP -> FETCH.
  - ERR -> ERR until reset.
- Outputs by state (any output not listed is 0; `alu_ctl` defaults to add):
  - FETCH: mem_rd, ir_wr, alu_src_b=01, pc_src=00, pc_wr.
  - DECODE: alu_src_b=11 (branch target into ALUOut).
  - MEM_ADR: alu_src_a=1, alu_src_b=10.
  - MEM_RD: mem_rd, iord.
  - MEM_WB: reg_wr, mem_to_reg.
  - MEM_WR: mem_wr, iord.
  - R_EX: alu_src_a=1, alu_src_b=00, alu_ctl from funct.
  - R_WB: reg_wr, reg_dst.
  - BR: alu_src_a=1, alu_ctl=110, pc_wr_cond, pc_src=01.
  - JMP: pc_wr, pc_src=10.
  - I_EX: alu_src_a=1, alu_src_b=10; alu_ctl=010 for addi, 001 plus ext_zero for ori.
  - I_WB: reg_wr, reg_dst=0; ext_zero held as in I_EX.
  - ERR: all enables 0, err=1.
- Outputs are Moore: combinational decode of the state register, plus latched opcode/funct for ALU control.
- While `rst`=0, every write enable (pc_wr, pc_wr_cond, pc_en, mem_wr, ir_wr, reg_wr) and mem_rd is forced to 0, regardless of state.
- Counters:
  - `cyc_cnt` increments every cycle that `rst`=1.
  - `inst_cnt` increments on each transition into FETCH from a final state (MEM_WB, MEM_WR, R_WB, I_WB, BR, JMP).
  - Both wrap modulo 2^CNT_W with no saturation.
  - ERR never retires an instruction.

## Timing
- Reset: the first clock edge with `rst`=0 loads state=FETCH, err=0, cyc_cnt=0, inst_cnt=0.
- After reset: outputs take FETCH values once `rst`=1.
- Reset asserted mid-instruction aborts it at the next edge, with no retire. Enables are gated in the same cycle.
- Latency in cycles, FETCH through final state: lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3.
- `opcode` and `funct` are sampled in DECODE and held in an internal register for the ALU-control decode in later states. The IR may change after DECODE without effect.
- `zero` is used only in BR, in the same cycle; `pc_en` is combinational from it.
- There is no handshake: the datapath memory is single-cycle and never stalls.

## Test plan
- Reset then R-type add (opcode 0, funct 100000): states 0,1,6,7,0; reg_wr=1 with reg_dst=1 only in R_WB; inst_cnt=1 and cyc_cnt=4 at the second FETCH.
- lw then sw: lw passes states 0,1,2,3,4 with iord=1 in MEM_RD; sw passes 0,1,2,5 with mem_wr=1 for exactly one cycle; inst_cnt=2 after 9 cycles.
- beq with zero=1, then beq with zero=0: pc_en=1 in BR only for the first; pc_src=01 both times; 3 cycles each.
- ori: alu_ctl=001 and ext_zero=1 in I_EX; reg_wr in I_WB. j: pc_src=10 and pc_wr=1 in JMP.
- Illegal opcode 111111, and R-type with funct 000000: state=15, err=1, inst_cnt frozen, cyc_cnt still counting; `rst` low one cycle returns state=0 and err=0.
- `rst` pulsed low during MEM_RD of an lw: mem_rd=0 and reg_wr=0 in that cycle; next state FETCH; inst_cnt=0. Separately, preload counters near 2^CNT_W-1 (CNT_W=4 build) and confirm wrap 15->0.
